imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 88 ++++++++
 tb/tb_imem_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// imem_ctrl: one-line instruction buffer that fetches misses over a request/grant/response bus with same-cycle bypass
module imem_ctrl #(
    parameter int TIMEOUT           = 64,
    parameter bit RESET_TAG_INVALID = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_addr,
    input  logic        inval,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        instr_fault,
    output logic        imem_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      r_state;
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic        r_buf_err;
    logic [29:0] r_req_tag;
    logic [7:0]  r_cnt;

    logic w_hit;
    logic w_bypass;
    logic w_timeout;
    logic w_fill;
    logic w_unused;

    assign w_unused    = &{1'b0, i_addr[1:0]};
    assign w_hit       = r_buf_valid && (r_buf_tag == i_addr[31:2]);
    assign w_bypass    = (r_state == WAIT) && mem_rvalid && !inval && (r_req_tag == i_addr[31:2]);
    assign w_timeout   = (r_state == WAIT) && !mem_rvalid && (r_cnt == 8'(TIMEOUT - 1));
    assign w_fill      = (r_state == WAIT) && (mem_rvalid || w_timeout);
    assign instr_valid = w_hit || w_bypass;
    assign instr       = w_hit ? (r_buf_err ? '0 : r_buf_data) : (w_bypass && !mem_err) ? mem_rdata : '0;
    assign instr_fault = w_hit ? r_buf_err : (w_bypass && mem_err);
    assign imem_stall  = ~instr_valid;
    assign mem_req     = (r_state == REQ);
    assign mem_addr    = mem_req ? {r_req_tag, 2'b00} : '0;

    // Miss sequencing: launch one request, hold it until granted, then wait for data or give up after TIMEOUT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_req_tag <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: if (!w_hit && !inval) begin
                    r_req_tag <= i_addr[31:2];
                    r_state   <= REQ;
                end
                REQ: if (mem_gnt) begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: if (mem_rvalid || w_timeout) r_state <= IDLE;
                      else r_cnt <= r_cnt + 8'd1;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line buffer: invalidate wins over a fill; a timeout fills a faulting zero word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= !RESET_TAG_INVALID;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_buf_err   <= 1'b0;
        end else if (inval) begin
            r_buf_valid <= 1'b0;
        end else if (w_fill) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_req_tag;
            r_buf_data  <= mem_rvalid ? mem_rdata : '0;
            r_buf_err   <= mem_rvalid ? mem_err : 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_imem_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_addr = '0;
    logic        inval = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_fault;
    logic        imem_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // model: the cached line and the single outstanding transaction
    logic        m_line_v;
    logic [29:0] m_line_tag;
    logic [31:0] m_line_data;
    logic        m_line_err;
    logic        m_out;
    logic        m_granted;
    logic [29:0] m_out_tag;
    int          m_age;

    // DUT outputs captured at the last checked cycle
    logic        c_iv, c_fault, c_stall, c_req;
    logic [31:0] c_instr, c_maddr;

    imem_ctrl #(.TIMEOUT(TO), .RESET_TAG_INVALID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .inval(inval),
        .instr(instr), .instr_valid(instr_valid), .instr_fault(instr_fault),
        .imem_stall(imem_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_line_v = 0; m_line_tag = '0; m_line_data = '0; m_line_err = 0;
        m_out = 0; m_granted = 0; m_out_tag = '0; m_age = 0;
    endtask

    // one cycle: drive, compare at the falling edge, advance the model, return just after the rising edge
    task automatic step(input logic [31:0] a, input logic inv, input logic g, input logic rv,
                        input logic [31:0] rd, input logic er);
        logic        hit, byp, ev, ef, ereq;
        logic [31:0] ei, ea;
        i_addr = a; inval = inv; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; mem_err = er;
        @(negedge clk);
        hit  = m_line_v && (m_line_tag == a[31:2]);
        byp  = m_out && m_granted && rv && !inv && (m_out_tag == a[31:2]);
        ev   = hit || byp;
        ei   = hit ? (m_line_err ? 32'h0 : m_line_data) : byp ? (er ? 32'h0 : rd) : 32'h0;
        ef   = hit ? m_line_err : (byp && er);
        ereq = m_out && !m_granted;
        ea   = ereq ? {m_out_tag, 2'b00} : 32'h0;
        c_iv = instr_valid; c_instr = instr; c_fault = instr_fault;
        c_stall = imem_stall; c_req = mem_req; c_maddr = mem_addr;
        chk("instr_valid", {31'b0, c_iv}, {31'b0, ev});
        chk("instr", c_instr, ei);
        chk("instr_fault", {31'b0, c_fault}, {31'b0, ef});
        chk("imem_stall", {31'b0, c_stall}, {31'b0, !ev});
        chk("mem_req", {31'b0, c_req}, {31'b0, ereq});
        chk("mem_addr", c_maddr, ea);
        if (m_out && m_granted) begin
            if (rv || m_age == TO - 1) begin
                if (!inv) begin
                    m_line_v = 1; m_line_tag = m_out_tag;
                    m_line_data = rv ? rd : 32'h0; m_line_err = rv ? er : 1'b1;
                end
                m_out = 0;
            end else m_age++;
        end else if (m_out) begin
            if (g) begin m_granted = 1; m_age = 0; end
        end else if (!hit && !inv) begin
            m_out = 1; m_granted = 0; m_out_tag = a[31:2];
        end
        if (inv) m_line_v = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, " mem_req"}, {31'b0, mem_req}, 32'h0);
        chk({n, " mem_addr"}, mem_addr, 32'h0);
        chk({n, " instr_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({n, " imem_stall"}, {31'b0, imem_stall}, 32'h1);
        chk({n, " instr"}, instr, 32'h0);
        chk({n, " instr_fault"}, {31'b0, instr_fault}, 32'h0);
    endtask

    initial begin
        logic [31:0] cur;
        model_reset();
        #2;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // cold miss with immediate grant and next-cycle data
        step(32'h80000000, 0, 0, 0, 0, 0);
        chk("cold miss detect", {31'b0, c_iv}, 32'h0);
        step(32'h80000000, 0, 1, 0, 0, 0);
        chk("cold mem_req", {31'b0, c_req}, 32'h1);
        chk("cold mem_addr", c_maddr, 32'h80000000);
        step(32'h80000000, 0, 0, 1, 32'h00000013, 0);
        chk("cold bypass valid", {31'b0, c_iv}, 32'h1);
        chk("cold bypass instr", c_instr, 32'h00000013);
        step(32'h80000000, 0, 0, 0, 0, 0);
        chk("cold hit instr", c_instr, 32'h00000013);
        chk("cold hit no req", {31'b0, c_req}, 32'h0);

        // grant held off for three cycles
        step(32'h80000004, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(32'h80000004, 0, i == 3, 0, 0, 0);
            chk("held mem_req", {31'b0, c_req}, 32'h1);
            chk("held mem_addr", c_maddr, 32'h80000004);
            chk("held stall", {31'b0, c_stall}, 32'h1);
        end
        step(32'h80000004, 0, 0, 1, 32'h00100093, 0);
        chk("held bypass instr", c_instr, 32'h00100093);

        // error response and a faulting hit afterwards
        step(32'h80000008, 0, 0, 0, 0, 0);
        step(32'h80000008, 0, 1, 0, 0, 0);
        step(32'h80000008, 0, 0, 1, 32'hdeadbeef, 1);
        chk("err bypass fault", {31'b0, c_fault}, 32'h1);
        chk("err bypass instr", c_instr, 32'h0);
        chk("err bypass valid", {31'b0, c_iv}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(32'h80000008, 0, 1, 0, 0, 0);
            chk("err hit fault", {31'b0, c_fault}, 32'h1);
            chk("err hit no req", {31'b0, c_req}, 32'h0);
        end

        // timeout with a late response afterwards
        step(32'h80000030, 0, 0, 0, 0, 0);
        step(32'h80000030, 0, 1, 0, 0, 0);
        for (int i = 0; i < TO; i++) begin
            step(32'h80000030, 0, 0, 0, 0, 0);
            chk("timeout waiting", {31'b0, c_iv}, 32'h0);
        end
        step(32'h80000030, 0, 0, 1, 32'h00000055, 0);
        chk("timeout fault", {31'b0, c_fault}, 32'h1);
        chk("timeout instr", c_instr, 32'h0);
        step(32'h80000030, 0, 0, 0, 0, 0);
        chk("late rsp ignored", {31'b0, c_fault}, 32'h1);
        chk("late rsp no req", {31'b0, c_req}, 32'h0);

        // invalidate racing a response
        step(32'h8000000C, 0, 0, 0, 0, 0);
        step(32'h8000000C, 0, 1, 0, 0, 0);
        step(32'h8000000C, 1, 0, 1, 32'h00000077, 0);
        chk("inval no bypass", {31'b0, c_iv}, 32'h0);
        step(32'h8000000C, 0, 0, 0, 0, 0);
        chk("inval no fill", {31'b0, c_iv}, 32'h0);
        step(32'h8000000C, 0, 1, 0, 0, 0);
        chk("inval refetch addr", c_maddr, 32'h8000000C);
        step(32'h8000000C, 0, 0, 1, 32'h00000077, 0);
        chk("inval refetch instr", c_instr, 32'h00000077);

        // address change mid-miss, then reset while waiting
        step(32'h80000010, 0, 0, 0, 0, 0);
        step(32'h80000010, 0, 1, 0, 0, 0);
        step(32'h80000020, 0, 0, 1, 32'h00000099, 0);
        chk("switch no bypass", {31'b0, c_iv}, 32'h0);
        step(32'h80000020, 0, 0, 0, 0, 0);
        step(32'h80000020, 0, 1, 0, 0, 0);
        chk("switch new addr", c_maddr, 32'h80000020);
        step(32'h80000010, 0, 0, 0, 0, 0);
        chk("switch old fill hit", c_instr, 32'h00000099);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        model_reset();
        #1;
        rst_n = 1'b1;
        step(32'h80000020, 0, 0, 1, 32'h00001234, 0);
        chk("post reset late rsp", {31'b0, c_iv}, 32'h0);

        // randomized traffic
        cur = 32'h80000000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                cur = 32'h80000000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            step(cur, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
